vr_beat_packer: RTL and testbench
=================================

// Module: vr_beat_packer
// PURPOSE
//  Downstream consumer of the valid/credit link's receive FIFO output. Packs up to BEATS
//  narrow DATA_W beats, beat 0 in the LSBs, into one wide word for the wide datapath.
//  Valid/ready on both sides; a beat with in_last closes a word early (partial word).
//  Double-buffered (fill reg + output reg) so the link side sustains 1 beat/cycle.
// PARAMETERS
//  DATA_W  8  width of one narrow beat
//  BEATS   4  beats per full wide word (>=2)
//  CNT_W   $clog2(BEATS+1)  localparam, width of out_cnt
// PORTS
//  clk        in   1             clock, all state on posedge
//  reset      in   1             async, active-high reset
//  in_valid   in   1             narrow beat valid
//  in_ready   out  1             packer accepts beat
//  in_data    in   DATA_W        narrow beat payload
//  in_last    in   1             beat closes current word
//  out_valid  out  1             wide word valid
//  out_ready  in   1             consumer accepts word
//  out_data   out  BEATS*DATA_W  packed word; unfilled lanes are zero
//  out_cnt    out  CNT_W         number of valid beats in out_data (1..BEATS)
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-word): fill_cnt=0, fill_data=0, pending=0,
//    out_valid=0, out_data=0, out_cnt=0; partial word in flight is discarded.
//  - Beat accepted = in_valid & in_ready. in_ready = !pending (registered state only;
//    no combinational path from in_* or out_ready to in_ready).
//  - Accepted beat written to lane fill_cnt; fill_cnt++.
//  - Closing beat = accepted & (in_last | fill_cnt==BEATS-1).
//  - out_free = !out_valid | out_ready.
//  - Closing beat & out_free: word (incl. this beat) loads output reg directly;
//    out_valid=1 next cycle; fill_cnt->0, fill_data->0. Latency closing beat->out_valid = 1.
//  - Closing beat & !out_free: word held in fill reg, pending=1, in_ready drops next cycle.
//  - pending & out_free: fill reg moves to output reg, pending=0, fill cleared;
//    in_ready high again next cycle.
//  - Output handshake: out_valid & out_ready with no new load -> out_valid=0,
//    out_data/out_cnt hold last value. out_data/out_cnt stable while out_valid & !out_ready.
//  - Output drain and new load in same cycle: new word wins, out_valid stays 1.
//  - out_cnt = beats in word; full word -> BEATS, in_last on first beat -> 1.
//  - fill_cnt never exceeds BEATS-1 at rest; wraps to 0 on close, no overflow possible.
//  - No beat accepted/dropped without in_ready; no word lost or duplicated.
// STRUCTURE
//  - vr_pack_pkg: typedefs beat_t (DATA_W), word_t (BEATS*DATA_W), cnt_t (CNT_W);
//    function lane_insert(word_t, beat_t, cnt_t) for lane write.
//  - Single module; no sub-module. Fill stage and output stage are two always_ff
//    blocks in this file.
// TESTING
//  1 Reset: assert reset mid-word (2 of 4 beats in) -> next word packs from lane 0;
//    all outputs 0 during reset.
//  2 Streaming, out_ready=1: beats 01,02,03,04,05.. -> out_data=0x04030201, cnt=4,
//    then 0x08070605; in_ready never drops; 1 word/4 cycles.
//  3 Early last: 0xAA, 0xBB+in_last -> out_data=0x0000BBAA, out_cnt=2;
//    single beat 0xCC+last -> 0x000000CC, cnt=1.
//  4 Backpressure: out_ready=0, 8 beats offered -> word1 held stable in out reg,
//    word2 pending, in_ready=0 after 8th beat; release -> word1 then word2, in order.
//  5 Same-cycle drain+load: out_valid=1, out_ready=1 on cycle closing beat accepted
//    -> out_valid stays 1 with new word next cycle, no bubble.
//  6 Random valid/ready with scoreboard, BEATS=2 and BEATS=4, 10k beats -> no loss,
//    no duplication, unused lanes 0.

Source files
------------

// File: rtl/vr_pack_pkg.sv
// Shared types and lane-write helper for the narrow-to-wide beat packer.
// The types are sized for the default 8-bit x 4-beat configuration.
package vr_pack_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_BEATS  = 4;
  localparam int DEF_CNT_W  = $clog2(DEF_BEATS + 1);

  typedef logic [DEF_DATA_W-1:0]           beat_t;
  typedef logic [DEF_BEATS*DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_CNT_W-1:0]            cnt_t;

  function automatic word_t lane_insert(input word_t w, input beat_t b, input cnt_t lane);
    word_t r;
    r = w;
    r[lane*DEF_DATA_W +: DEF_DATA_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/vr_beat_packer.sv
// Packs up to BEATS narrow beats (beat 0 in LSBs) into one wide word; in_last closes early.
// Fill reg + output reg so the narrow side keeps 1 beat/cycle; closing beat -> out_valid in 1 cycle.
module vr_beat_packer
  import vr_pack_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int BEATS  = DEF_BEATS,
  localparam int CNT_W  = $clog2(BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BEATS*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_cnt
);

  localparam int               WORD_W    = BEATS * DATA_W;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]  fill_cnt;
  logic [WORD_W-1:0] fill_data;
  logic [WORD_W-1:0] word_next;
  logic              pending;
  logic              accept;
  logic              closing;
  logic              out_free;

  // in_ready depends on registered state only, never on in_* or out_ready.
  assign in_ready = !pending;
  assign accept   = in_valid & in_ready;
  assign closing  = accept & (in_last | (fill_cnt == LAST_LANE));
  assign out_free = !out_valid | out_ready;

  generate
    if (DATA_W == DEF_DATA_W && BEATS == DEF_BEATS) begin : g_pkg_lane
      assign word_next = lane_insert(fill_data, in_data, fill_cnt);
    end else begin : g_gen_lane
      always_comb begin
        word_next = fill_data;
        word_next[fill_cnt*DATA_W +: DATA_W] = in_data;
      end
    end
  endgenerate

  // Fill stage: while pending, fill_cnt holds the beat count of the parked word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt  <= '0;
      fill_data <= '0;
      pending   <= 1'b0;
    end else if (pending && out_free) begin
      fill_cnt  <= '0;
      fill_data <= '0;
      pending   <= 1'b0;
    end else if (accept) begin
      if (closing && out_free) begin
        fill_cnt  <= '0;
        fill_data <= '0;
      end else begin
        fill_data <= word_next;
        fill_cnt  <= fill_cnt + CNT_W'(1);
        pending   <= closing;
      end
    end
  end

  // Output stage: a new load takes priority over a drain in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else if (pending && out_free) begin
      out_valid <= 1'b1;
      out_data  <= fill_data;
      out_cnt   <= fill_cnt;
    end else if (closing && out_free) begin
      out_valid <= 1'b1;
      out_data  <= word_next;
      out_cnt   <= fill_cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vr_beat_packer.sv
// Directed checks on a 4-beat packer, then randomized valid/ready traffic on 4-beat and 2-beat packers.
module tb_vr_beat_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic [2:0]  out_cnt;
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vr_beat_packer #(.DATA_W(8), .BEATS(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
  );

  vr_beat_packer #(.DATA_W(8), .BEATS(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_cnt(b_out_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  localparam int N_BEATS = 10000;
  localparam int BUDGET  = 60000;

  logic [31:0] q4[$];
  logic [2:0]  qc4[$];
  logic [15:0] q2[$];
  logic [1:0]  qc2[$];
  logic [31:0] m4;
  logic [15:0] m2;
  int          mc4, mc2, sent4, sent2, cyc;
  logic        acc4, acc2, rdy_ok;

  initial begin
    reset = 1'b1;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    reset = 1'b0;
    out_ready = 1'b1;

    // Reset mid-word: the two parked beats must be discarded.
    send(8'h11, 0);
    send(8'h22, 0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    step();
    reset = 1'b0;
    send(8'h33, 1);
    chk("postrst_data", out_data, 32'h0000_0033);
    chk("postrst_cnt", out_cnt, 1);
    step();
    chk("postrst_drain", out_valid, 0);

    // Streaming with out_ready held high.
    rdy_ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_last  = 1'b0;
      if (!in_ready) rdy_ok = 1'b0;
      step();
      if (i == 4) begin
        chk("stream_w1_valid", out_valid, 1);
        chk("stream_w1_data", out_data, 32'h0403_0201);
        chk("stream_w1_cnt", out_cnt, 4);
      end
      if (i == 5) chk("stream_gap", out_valid, 0);
      if (i == 8) begin
        chk("stream_w2_data", out_data, 32'h0807_0605);
        chk("stream_w2_cnt", out_cnt, 4);
      end
    end
    in_valid = 1'b0;
    chk("stream_in_ready", rdy_ok, 1);
    step();

    // Early last: partial words with zeroed upper lanes.
    send(8'hAA, 0);
    send(8'hBB, 1);
    chk("early2_data", out_data, 32'h0000_BBAA);
    chk("early2_cnt", out_cnt, 2);
    send(8'hCC, 1);
    chk("early1_data", out_data, 32'h0000_00CC);
    chk("early1_cnt", out_cnt, 1);
    step();
    chk("early_drain", out_valid, 0);

    // Backpressure: one word in the output reg, one parked in the fill reg.
    out_ready = 1'b0;
    rdy_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      in_last  = 1'b0;
      if (!in_ready) rdy_ok = 1'b0;
      step();
      if (i == 3) chk("bp_w1_data", out_data, 32'h1312_1110);
    end
    chk("bp_in_ready_during", rdy_ok, 1);
    chk("bp_in_ready_after", in_ready, 0);
    in_data = 8'h99;
    in_last = 1'b1;
    step();
    step();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 32'h1312_1110);
    chk("bp_hold_cnt", out_cnt, 4);
    chk("bp_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_w2_data", out_data, 32'h1716_1514);
    chk("bp_w2_valid", out_valid, 1);
    chk("bp_release_in_ready", in_ready, 1);
    step();
    chk("bp_w3_data", out_data, 32'h0000_0099);
    chk("bp_w3_cnt", out_cnt, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    chk("bp_drain", out_valid, 0);

    // Drain and load in the same cycle: no bubble.
    send(8'h41, 1);
    chk("dl_w1_data", out_data, 32'h0000_0041);
    send(8'h42, 1);
    chk("dl_w2_valid", out_valid, 1);
    chk("dl_w2_data", out_data, 32'h0000_0042);
    step();
    chk("dl_drain", out_valid, 0);

    // Random traffic on both widths with a scoreboard.
    m4 = 0; m2 = 0; mc4 = 0; mc2 = 0; sent4 = 0; sent2 = 0; cyc = 0;
    while ((sent4 < N_BEATS || sent2 < N_BEATS) && cyc < BUDGET) begin
      if (!in_valid && sent4 < N_BEATS && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_last  = (sent4 == N_BEATS - 1) || ($urandom_range(0, 5) == 0);
      end
      if (!b_in_valid && sent2 < N_BEATS && $urandom_range(0, 3) != 0) begin
        b_in_valid = 1'b1;
        b_in_data  = 8'($urandom);
        b_in_last  = (sent2 == N_BEATS - 1) || ($urandom_range(0, 5) == 0);
      end
      out_ready   = ($urandom_range(0, 2) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      acc4 = in_valid && in_ready;
      acc2 = b_in_valid && b_in_ready;
      if (acc4) begin
        m4 = m4 | (32'(in_data) << (8 * mc4));
        mc4++;
        sent4++;
        if (in_last || mc4 == 4) begin
          q4.push_back(m4); qc4.push_back(3'(mc4));
          m4 = 0; mc4 = 0;
        end
      end
      if (acc2) begin
        m2 = m2 | (16'(b_in_data) << (8 * mc2));
        mc2++;
        sent2++;
        if (b_in_last || mc2 == 2) begin
          q2.push_back(m2); qc2.push_back(2'(mc2));
          m2 = 0; mc2 = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (q4.size() == 0) chk("rnd4_extra_word", 1, 0);
        else begin
          chk("rnd4_data", out_data, q4.pop_front());
          chk("rnd4_cnt", out_cnt, qc4.pop_front());
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (q2.size() == 0) chk("rnd2_extra_word", 1, 0);
        else begin
          chk("rnd2_data", b_out_data, q2.pop_front());
          chk("rnd2_cnt", b_out_cnt, qc2.pop_front());
        end
      end
      step();
      cyc++;
      if (acc4) begin in_valid = 1'b0; in_last = 1'b0; end
      if (acc2) begin b_in_valid = 1'b0; b_in_last = 1'b0; end
    end
    chk("rnd_cycle_budget", (cyc < BUDGET), 1);
    in_valid = 1'b0; b_in_valid = 1'b0;
    out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (6) begin
      if (out_valid) begin
        if (q4.size() == 0) chk("rnd4_extra_word", 1, 0);
        else begin
          chk("rnd4_data", out_data, q4.pop_front());
          chk("rnd4_cnt", out_cnt, qc4.pop_front());
        end
      end
      if (b_out_valid) begin
        if (q2.size() == 0) chk("rnd2_extra_word", 1, 0);
        else begin
          chk("rnd2_data", b_out_data, q2.pop_front());
          chk("rnd2_cnt", b_out_cnt, qc2.pop_front());
        end
      end
      step();
    end
    chk("rnd4_words_left", q4.size(), 0);
    chk("rnd2_words_left", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
